data_mem_responder: RTL

//  Memory-side slave for the core's data port: answers req/gnt/rvalid transactions issued by the load/store stage.

---
 rtl/data_mem_responder_pkg.sv | 31 +++
 rtl/data_mem_responder_if.sv | 28 ++
 rtl/data_mem_responder_be_ram.sv | 45 ++++
 rtl/data_mem_responder.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_responder_pkg
//   Shared definitions for the data-port memory responder.
//   - state_e          : responder FSM states
//   - bus widths       : address / data / byte-enable widths
//   - ERR_RDATA_DEFAULT: word returned for out-of-range loads
//   - addr_in_range()  : word-index range check against the RAM depth
// -----------------------------------------------------------------------------
package data_mem_responder_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  localparam logic [DATA_W-1:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GNT  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // The word index is addr[31:2]; the low two bits never select a word.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                         input int unsigned      depth_words);
    logic [ADDR_W-1:0] word_idx;
    word_idx = {2'b00, addr[ADDR_W-1:2]};
    return (word_idx < depth_words);
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// -----------------------------------------------------------------------------
// data_mem_if
//   req/gnt/rvalid data-port bus between the load/store stage (master) and the
//   memory responder (slave).
//   req, addr, we, be, wdata : master -> slave request fields
//   gnt                      : slave accepts the request this cycle
//   rvalid, rdata, err       : one-cycle response pulse with load data / error
// -----------------------------------------------------------------------------
interface data_mem_if;
  import data_mem_responder_pkg::*;

  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [BE_W-1:0]   be;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (output req, addr, we, be, wdata,
                  input  gnt, rvalid, rdata, err);

  modport slave  (input  req, addr, we, be, wdata,
                  output gnt, rvalid, rdata, err);

endinterface

// File: rtl/data_mem_responder_be_ram.sv
// -----------------------------------------------------------------------------
// data_mem_responder_be_ram
//   DEPTH_WORDS x 32 storage with four byte-lane write enables and a
//   registered (synchronous) read port.
//   clk      : clock
//   wr_be    : per-lane write enables (all zero = no write)
//   rd_en    : capture mem[idx] into rdata at this edge
//   idx      : word index
//   wdata    : lane-aligned write data
//   rdata    : last word read, held until the next rd_en
// -----------------------------------------------------------------------------
module data_mem_responder_be_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic             clk,
  input  logic [3:0]       wr_be,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem_r [DEPTH_WORDS];
  logic [31:0] rdata_r;

  // Byte-lane writes; storage is deliberately not reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_be[b]) begin
        mem_r[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Synchronous read port, holds its value between reads.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rdata_r <= mem_r[idx];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//   Memory-side slave for the core data port. One transaction outstanding;
//   programmable grant and response wait states.
//   clk     : clock
//   reset   : synchronous, active-high reset
//   stall_i : backpressure, forces gnt low while high
//   busy_o  : high whenever the FSM is not idle
//   bus     : data_mem_if slave port (req/gnt/rvalid bus)
// -----------------------------------------------------------------------------
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          GNT_WAIT    = 0,
  parameter int          RVALID_WAIT = 1,
  parameter logic [31:0] ERR_RDATA   = ERR_RDATA_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stall_i,
  output logic       busy_o,
  data_mem_if.slave  bus
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int GW    = (GNT_WAIT > 1)    ? $clog2(GNT_WAIT)    : 1;
  localparam int RW    = (RVALID_WAIT > 1) ? $clog2(RVALID_WAIT) : 1;

  localparam logic [GW-1:0] GNT_LOAD  = GW'((GNT_WAIT > 0) ? GNT_WAIT - 1 : 0);
  localparam logic [RW-1:0] RESP_LOAD = RW'(RVALID_WAIT - 1);

  state_e        state_r;
  logic [GW-1:0] gnt_cnt_r;
  logic [RW-1:0] resp_cnt_r;
  logic          rvalid_r;
  logic          we_cap_r;
  logic          err_cap_r;
  logic [31:0]   hold_r;

  logic          gnt_s;
  logic          accept_s;
  logic          oor_s;
  logic [3:0]    wr_be_s;
  logic          rd_en_s;
  logic [31:0]   ram_rdata_s;
  logic [31:0]   rdata_s;

  assign oor_s    = ~addr_in_range(bus.addr, DEPTH_WORDS);
  assign accept_s = gnt_s & bus.req;

  // Grant decode: combinational so a zero-wait grant lands in the req cycle.
  always_comb begin
    gnt_s = 1'b0;
    if (reset) begin
      gnt_s = 1'b0;
    end else begin
      case (state_r)
        S_IDLE:  gnt_s = (GNT_WAIT == 0) ? (bus.req & ~stall_i) : 1'b0;
        S_GNT:   gnt_s = bus.req & ~stall_i & (gnt_cnt_r == GW'(0));
        default: gnt_s = 1'b0;
      endcase
    end
  end

  // RAM strobes: out-of-range stores never touch storage.
  always_comb begin
    wr_be_s = 4'b0000;
    rd_en_s = 1'b0;
    if (accept_s && !oor_s) begin
      wr_be_s = bus.we ? bus.be : 4'b0000;
      rd_en_s = ~bus.we;
    end else begin
      wr_be_s = 4'b0000;
      rd_en_s = 1'b0;
    end
  end

  data_mem_responder_be_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_ram (
    .clk   (clk),
    .wr_be (wr_be_s),
    .rd_en (rd_en_s),
    .idx   (bus.addr[IDX_W+1:2]),
    .wdata (bus.wdata),
    .rdata (ram_rdata_s)
  );

  // Transaction FSM: grant wait, accept capture, response countdown.
  // rvalid_r is raised on the edge that enters the final S_RESP cycle, so the
  // pulse sits exactly RVALID_WAIT cycles after the accept cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_IDLE;
      gnt_cnt_r  <= GW'(0);
      resp_cnt_r <= RW'(0);
      rvalid_r   <= 1'b0;
      we_cap_r   <= 1'b0;
      err_cap_r  <= 1'b0;
    end else begin
      rvalid_r <= 1'b0;
      if (accept_s) begin
        state_r    <= S_RESP;
        resp_cnt_r <= RESP_LOAD;
        we_cap_r   <= bus.we;
        err_cap_r  <= oor_s;
        rvalid_r   <= (RVALID_WAIT == 1);
      end else begin
        case (state_r)
          S_IDLE: begin
            if (GNT_WAIT != 0 && bus.req) begin
              gnt_cnt_r <= GNT_LOAD;
              state_r   <= S_GNT;
            end
          end
          S_GNT: begin
            if (!bus.req) begin
              state_r <= S_IDLE;
            end else if (!stall_i && gnt_cnt_r != GW'(0)) begin
              gnt_cnt_r <= gnt_cnt_r - GW'(1);
            end
          end
          S_RESP: begin
            if (resp_cnt_r == RW'(0)) begin
              state_r <= S_IDLE;
            end else begin
              resp_cnt_r <= resp_cnt_r - RW'(1);
              rvalid_r   <= (resp_cnt_r == RW'(1));
            end
          end
          default: state_r <= S_IDLE;
        endcase
      end
    end
  end

  // Response data: stores leave the previous load data on the bus.
  always_comb begin
    rdata_s = hold_r;
    if (rvalid_r && !we_cap_r) begin
      rdata_s = err_cap_r ? ERR_RDATA : ram_rdata_s;
    end else begin
      rdata_s = hold_r;
    end
  end

  // Keeps rdata stable between response pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_r <= 32'h0000_0000;
    end else if (rvalid_r) begin
      hold_r <= rdata_s;
    end
  end

  assign bus.gnt    = gnt_s;
  assign bus.rvalid = rvalid_r;
  assign bus.rdata  = rdata_s;
  assign bus.err    = rvalid_r & err_cap_r;
  assign busy_o     = (state_r != S_IDLE);

endmodule
